// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC time-field units: write-sequencer states,
// bus constants, field register addresses and the binary-to-BCD helper.
package rtc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_SETUP,
    ADDR_WR,
    ADDR_HOLD,
    DATA_SETUP,
    DATA_WR,
    DATA_HOLD,
    DONE
  } wr_state_t;

  localparam logic [7:0] BUS_IDLE_DATA = 8'h00;

  localparam logic [7:0] ADDR_SEC   = 8'h20;
  localparam logic [7:0] ADDR_MIN   = 8'h21;
  localparam logic [7:0] ADDR_HOUR  = 8'h22;
  localparam logic [7:0] ADDR_DAY   = 8'h23;
  localparam logic [7:0] ADDR_MONTH = 8'h24;
  localparam logic [7:0] ADDR_YEAR  = 8'h25;

  // Valid for 0..99; every field modulus is capped at 100.
  function automatic logic [7:0] bin2bcd(input logic [6:0] bin);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(bin / 7'd10);
    units = 4'(bin % 7'd10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/rtc_bus_write_seq.sv
// Write sequencer for the multiplexed RTC bus: address phase then data phase,
// each split into setup / strobe / hold, timed by one shared down-counter.
//
// state      | meaning
// IDLE       | bus released, waiting for start
// ADDR_SETUP | address driven, cs_n low, wr_n high
// ADDR_WR    | address strobe, wr_n low
// ADDR_HOLD  | address held after wr_n rises
// DATA_SETUP | latched data driven, wr_n high
// DATA_WR    | data strobe, wr_n low
// DATA_HOLD  | data held after wr_n rises
// DONE       | bus released, one-cycle done pulse
module rtc_bus_write_seq
  import rtc_pkg::*;
#(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad,
  output logic [7:0] bus_data,
  output logic       bus_oe,
  output logic       busy,
  output logic       done
);

  localparam int T_MAX = (T_SETUP > T_PULSE) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                             : ((T_PULSE > T_HOLD) ? T_PULSE : T_HOLD);
  localparam int TMR_W = $clog2(T_MAX) + 1;

  localparam logic [TMR_W-1:0] LD_SETUP = TMR_W'(T_SETUP - 1);
  localparam logic [TMR_W-1:0] LD_PULSE = TMR_W'(T_PULSE - 1);
  localparam logic [TMR_W-1:0] LD_HOLD  = TMR_W'(T_HOLD - 1);

  wr_state_t        state, next_state;
  logic [TMR_W-1:0] tmr, tmr_next;
  logic [7:0]       data_lat, data_lat_next;
  logic             cs_n_next, wr_n_next, ad_next, bus_oe_next, busy_next, done_next;
  logic [7:0]       bus_data_next;

  assign rd_n = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tmr      <= '0;
      data_lat <= 8'h00;
      cs_n     <= 1'b1;
      wr_n     <= 1'b1;
      ad       <= 1'b1;
      bus_data <= BUS_IDLE_DATA;
      bus_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= next_state;
      tmr      <= tmr_next;
      data_lat <= data_lat_next;
      cs_n     <= cs_n_next;
      wr_n     <= wr_n_next;
      ad       <= ad_next;
      bus_data <= bus_data_next;
      bus_oe   <= bus_oe_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

  always_comb begin
    next_state    = state;
    tmr_next      = (tmr != '0) ? tmr - 1'b1 : tmr;
    data_lat_next = data_lat;

    case (state)
      IDLE: if (start) begin
        next_state    = ADDR_SETUP;
        tmr_next      = LD_SETUP;
        data_lat_next = data;
      end
      ADDR_SETUP: if (tmr == '0) begin next_state = ADDR_WR;    tmr_next = LD_PULSE; end
      ADDR_WR:    if (tmr == '0) begin next_state = ADDR_HOLD;  tmr_next = LD_HOLD;  end
      ADDR_HOLD:  if (tmr == '0) begin next_state = DATA_SETUP; tmr_next = LD_SETUP; end
      DATA_SETUP: if (tmr == '0) begin next_state = DATA_WR;    tmr_next = LD_PULSE; end
      DATA_WR:    if (tmr == '0) begin next_state = DATA_HOLD;  tmr_next = LD_HOLD;  end
      DATA_HOLD:  if (tmr == '0) begin next_state = DONE;       tmr_next = '0;       end
      DONE:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    cs_n_next     = 1'b1;
    wr_n_next     = 1'b1;
    ad_next       = 1'b1;
    bus_data_next = BUS_IDLE_DATA;
    bus_oe_next   = 1'b0;
    busy_next     = (next_state != IDLE);
    done_next     = (next_state == DONE);

    case (next_state)
      ADDR_SETUP, ADDR_WR, ADDR_HOLD: begin
        cs_n_next     = 1'b0;
        ad_next       = 1'b0;
        bus_data_next = addr;
        bus_oe_next   = 1'b1;
        wr_n_next     = (next_state != ADDR_WR);
      end
      DATA_SETUP, DATA_WR, DATA_HOLD: begin
        cs_n_next     = 1'b0;
        bus_data_next = data_lat_next;
        bus_oe_next   = 1'b1;
        wr_n_next     = (next_state != DATA_WR);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rtc_field_writer.sv
// One RTC time field: modulo up/down counter edited by up/down edges, BCD view
// of the count, and a bus write sequencer that pushes a snapshot to the RTC.
module rtc_field_writer
  import rtc_pkg::*;
#(
  parameter int         MODULUS   = 60,
  parameter int         RESET_VAL = 0,
  parameter logic [7:0] REG_ADDR  = 8'h21,
  parameter int         T_SETUP   = 2,
  parameter int         T_PULSE   = 4,
  parameter int         T_HOLD    = 2,
  localparam int        CNT_W     = $clog2(MODULUS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adj_en,
  input  logic             up,
  input  logic             down,
  input  logic             wr_req,
  output logic [CNT_W-1:0] value,
  output logic [7:0]       bcd,
  output logic [7:0]       bus_data,
  output logic             bus_oe,
  output logic             cs_n,
  output logic             rd_n,
  output logic             wr_n,
  output logic             ad,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MODULUS - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RESET_VAL);

  logic up_prev, down_prev;
  logic up_rise, down_rise;

  assign up_rise   = up & ~up_prev;
  assign down_rise = down & ~down_prev;

  // Prev levels track continuously so edges seen while locked out are lost, not deferred.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_prev   <= 1'b0;
      down_prev <= 1'b0;
      value     <= CNT_INIT;
    end else begin
      up_prev   <= up;
      down_prev <= down;
      if (adj_en && !busy) begin
        if (up_rise && !down_rise)
          value <= (value == CNT_MAX) ? '0 : value + CNT_W'(1);
        else if (down_rise && !up_rise)
          value <= (value == '0) ? CNT_MAX : value - CNT_W'(1);
      end
    end
  end

  assign bcd = bin2bcd(7'(value));

  rtc_bus_write_seq #(
    .T_SETUP (T_SETUP),
    .T_PULSE (T_PULSE),
    .T_HOLD  (T_HOLD)
  ) u_seq (
    .clk      (clk),
    .reset    (reset),
    .start    (wr_req),
    .addr     (REG_ADDR),
    .data     (bcd),
    .cs_n     (cs_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .ad       (ad),
    .bus_data (bus_data),
    .bus_oe   (bus_oe),
    .busy     (busy),
    .done     (done)
  );

endmodule

// File: tb/tb_rtc_field_writer.sv
// Bench for rtc_field_writer: a 60-count and a 24-count field sharing the edit
// inputs, checked against arithmetic models of the count and the bus timing.
module tb_rtc_field_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       adj_en = 1'b0, up = 1'b0, down = 1'b0;
  logic       wr_req = 1'b0, wr_req_b = 1'b0;

  logic [5:0] value_a;
  logic [7:0] bcd_a, bus_data_a;
  logic       bus_oe_a, cs_n_a, rd_n_a, wr_n_a, ad_a, busy_a, done_a;

  logic [4:0] value_b;
  logic [7:0] bcd_b, bus_data_b;
  logic       bus_oe_b, cs_n_b, rd_n_b, wr_n_b, ad_b, busy_b, done_b;

  int ref_a = 0, ref_b = 0;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  rtc_field_writer dut_a (
    .clk(clk), .reset(reset), .adj_en(adj_en), .up(up), .down(down), .wr_req(wr_req),
    .value(value_a), .bcd(bcd_a), .bus_data(bus_data_a), .bus_oe(bus_oe_a),
    .cs_n(cs_n_a), .rd_n(rd_n_a), .wr_n(wr_n_a), .ad(ad_a), .busy(busy_a), .done(done_a)
  );

  rtc_field_writer #(.MODULUS(24)) dut_b (
    .clk(clk), .reset(reset), .adj_en(adj_en), .up(up), .down(down), .wr_req(wr_req_b),
    .value(value_b), .bcd(bcd_b), .bus_data(bus_data_b), .bus_oe(bus_oe_b),
    .cs_n(cs_n_b), .rd_n(rd_n_b), .wr_n(wr_n_b), .ad(ad_b), .busy(busy_b), .done(done_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vals(input string tag);
    check_eq({tag, "_val_a"}, value_a, ref_a);
    check_eq({tag, "_bcd_a"}, bcd_a, to_bcd(ref_a));
    check_eq({tag, "_val_b"}, value_b, ref_b);
    check_eq({tag, "_bcd_b"}, bcd_b, to_bcd(ref_b));
  endtask

  // One pulse on up and/or down; both fields are idle here so both may count.
  task automatic edge_op(input bit u, input bit d, input string tag);
    up = u;
    down = d;
    tick();
    if (adj_en && (u != d)) begin
      ref_a = u ? (ref_a + 1) % 60 : (ref_a + 59) % 60;
      ref_b = u ? (ref_b + 1) % 24 : (ref_b + 23) % 24;
    end
    up = 1'b0;
    down = 1'b0;
    tick();
    check_vals(tag);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_cs_n"}, cs_n_a, 1);
    check_eq({tag, "_wr_n"}, wr_n_a, 1);
    check_eq({tag, "_rd_n"}, rd_n_a, 1);
    check_eq({tag, "_ad"}, ad_a, 1);
    check_eq({tag, "_oe"}, bus_oe_a, 0);
    check_eq({tag, "_data"}, bus_data_a, 0);
    check_eq({tag, "_busy"}, busy_a, 0);
    check_eq({tag, "_done"}, done_a, 0);
  endtask

  // Cycle i (1-based) after the accepting edge: 1-8 address phase, 9-16 data
  // phase (each 2 setup, 4 strobe, 2 hold), 17 done.
  task automatic run_txn(input int up_at, input int abort_at);
    int exp_data, p, wr_low_a, wr_low_d;
    exp_data = to_bcd(ref_a);
    wr_low_a = 0;
    wr_low_d = 0;
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      if (i == abort_at) begin
        #2 reset = 1'b1;
        #1;
        ref_a = 0;
        ref_b = 0;
        check_eq("abort_cs_n", cs_n_a, 1);
        check_eq("abort_wr_n", wr_n_a, 1);
        check_eq("abort_oe", bus_oe_a, 0);
        check_eq("abort_busy", busy_a, 0);
        check_eq("abort_val", value_a, 0);
        check_eq("abort_data", bus_data_a, 0);
        return;
      end
      p = (i - 1) % 8;
      check_eq("txn_cs_n", cs_n_a, (i <= 16) ? 0 : 1);
      check_eq("txn_wr_n", wr_n_a, (i <= 16 && p >= 2 && p <= 5) ? 0 : 1);
      check_eq("txn_rd_n", rd_n_a, 1);
      check_eq("txn_ad", ad_a, (i <= 8) ? 0 : 1);
      check_eq("txn_oe", bus_oe_a, (i <= 16) ? 1 : 0);
      check_eq("txn_data", bus_data_a, (i <= 8) ? 32'h21 : (i <= 16) ? exp_data : 0);
      check_eq("txn_busy", busy_a, 1);
      check_eq("txn_done", done_a, (i == 17) ? 1 : 0);
      if (wr_n_a === 1'b0 && i <= 8) wr_low_a++;
      if (wr_n_a === 1'b0 && i > 8) wr_low_d++;
      if (i == up_at) up = 1'b1;
      if (i == up_at + 2) up = 1'b0;
      tick();
      // The 24-count field is never busy, so it takes the edge the 60-count field drops.
      if (i == up_at && adj_en) ref_b = (ref_b + 1) % 24;
    end
    check_eq("txn_wr_low_addr", wr_low_a, 4);
    check_eq("txn_wr_low_data", wr_low_d, 4);
    check_idle("txn_end");
    check_vals("txn_end");
  endtask

  initial begin
    reset = 1'b1;
    tick();
    tick();
    check_vals("reset");
    check_idle("reset");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_idle("idle");
      check_eq("idle_val", value_a, 0);
    end

    adj_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      edge_op(1'b1, 1'b0, "up_run");
      if (i == 58) check_eq("reach_59", value_a, 59);
    end
    check_eq("wrap_0", value_a, 0);
    edge_op(1'b0, 1'b1, "down_wrap");
    check_eq("down_wrap_59", value_a, 59);

    while (ref_a != 30) edge_op(1'b0, 1'b1, "to_30");
    edge_op(1'b1, 1'b1, "both");
    check_eq("both_30", value_a, 30);
    adj_en = 1'b0;
    edge_op(1'b1, 1'b0, "adj_off");
    check_eq("adj_off_30", value_a, 30);
    adj_en = 1'b1;

    while (ref_a != 45) edge_op(1'b1, 1'b0, "to_45");
    run_txn(5, 0);
    check_eq("busy_up_45", value_a, 45);
    run_txn(0, 0);

    for (int n = 0; n < 150; n++) begin
      adj_en = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 2))
        0: edge_op(1'b1, 1'b0, "rnd_up");
        1: edge_op(1'b0, 1'b1, "rnd_dn");
        default: edge_op(1'b1, 1'b1, "rnd_both");
      endcase
      if (n % 50 == 49) run_txn(0, 0);
    end
    adj_en = 1'b1;

    run_txn(0, 12);
    tick();
    reset = 1'b0;
    tick();
    check_idle("post_abort");
    check_vals("post_abort");

    edge_op(1'b0, 1'b1, "mod24_down");
    check_eq("mod24_val_23", value_b, 23);
    check_eq("mod24_bcd_23", bcd_b, 32'h23);
    check_eq("mod60_val_59", value_a, 59);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
